// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the reverse key schedule: round count,
// inverse rcon stepping, RotWord and the generator state encoding.
package aes_pkg;

  localparam int         AES128_ROUNDS = 10;
  localparam int         KEY_W         = 128;
  localparam int         WORD_W        = 32;
  localparam logic [7:0] RCON_LAST     = 8'h36;

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_t;

  // Division by x in GF(2^8): undoes the forward xtime used to advance rcon.
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    return r[0] ? (((r ^ 8'h1b) >> 1) | 8'h80) : (r >> 1);
  endfunction

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_rev_step.sv
// One combinational inverse key-schedule step: derives round key N-1 from
// round key N, using an external S-box for the SubWord term.
module aes_key_rev_step
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0]  i_work,
  input  logic [7:0]        i_rcon,
  input  logic [WORD_W-1:0] i_new_sboxw,
  output logic [WORD_W-1:0] o_sboxw,
  output logic [KEY_W-1:0]  o_prev_key
);

  logic [WORD_W-1:0] w_w0, w_w1, w_w2, w_w3;
  logic [WORD_W-1:0] w_p0, w_p1, w_p2, w_p3;

  assign w_w0 = i_work[127:96];
  assign w_w1 = i_work[95:64];
  assign w_w2 = i_work[63:32];
  assign w_w3 = i_work[31:0];

  // Words 1..3 fall out of neighbouring XORs; word 3 of the previous key
  // then feeds SubWord(RotWord()) to recover word 0.
  assign w_p3 = w_w3 ^ w_w2;
  assign w_p2 = w_w2 ^ w_w1;
  assign w_p1 = w_w1 ^ w_w0;

  assign o_sboxw = rot_word(w_p3);
  assign w_p0    = w_w0 ^ i_new_sboxw ^ {i_rcon, 24'h0};

  assign o_prev_key = {w_p0, w_p1, w_p2, w_p3};

endmodule

// File: rtl/aes_key_mem_rev.sv
// Reverse AES-128 key schedule: from the round-10 key, walks back one round
// per cycle and stores all 11 round keys for random-access reads.
module aes_key_mem_rev
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  input  logic [KEY_W-1:0]  last_key,
  input  logic [3:0]        round,
  output logic [KEY_W-1:0]  round_key,
  output logic              ready,
  output logic              valid,
  output logic [WORD_W-1:0] sboxw,
  input  logic [WORD_W-1:0] new_sboxw
);

  state_t           r_state;
  logic [3:0]       r_ctr;
  logic [7:0]       r_rcon;
  logic [KEY_W-1:0] r_work;
  logic             r_ready;
  logic             r_valid;
  logic [KEY_W-1:0] r_key [0:AES128_ROUNDS];

  logic [WORD_W-1:0] w_sboxw;
  logic [KEY_W-1:0]  w_prev_key;
  logic [3:0]        w_wr_idx;

  aes_key_rev_step u_step (
    .i_work      (r_work),
    .i_rcon      (r_rcon),
    .i_new_sboxw (new_sboxw),
    .o_sboxw     (w_sboxw),
    .o_prev_key  (w_prev_key)
  );

  assign w_wr_idx = r_ctr - 4'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ctr   <= '0;
      r_rcon  <= '0;
      r_work  <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      for (int i = 0; i <= AES128_ROUNDS; i++) begin
        r_key[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (init) begin
            r_key[AES128_ROUNDS] <= last_key;
            r_work               <= last_key;
            r_rcon               <= RCON_LAST;
            r_ctr                <= 4'(AES128_ROUNDS);
            r_ready              <= 1'b0;
            r_valid              <= 1'b0;
            r_state              <= GEN;
          end
        end
        GEN: begin
          // r_ctr names the key held in r_work; its predecessor lands at r_ctr-1.
          r_key[w_wr_idx] <= w_prev_key;
          r_work          <= w_prev_key;
          r_ctr           <= w_wr_idx;
          r_rcon          <= inv_xtime(r_rcon);
          if (r_ctr == 4'd1) begin
            r_ready <= 1'b1;
            r_valid <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The S-box is only ours while generating; keep the request bus quiet otherwise.
  assign sboxw     = (r_state == GEN) ? w_sboxw : '0;
  assign round_key = (round <= 4'(AES128_ROUNDS)) ? r_key[round] : '0;
  assign ready     = r_ready;
  assign valid     = r_valid;

endmodule

// File: tb/tb_aes_key_mem_rev.sv
// Directed bench for aes_key_mem_rev with a behavioural S-box and a forward
// key-expansion model used to cross-check whole schedules.
module tb_aes_key_mem_rev;

  logic         clk;
  logic         reset_n;
  logic         init;
  logic [127:0] last_key;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic         valid;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] FIPS_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK9  = 128'hac7766f319fadc2128d12941575c006e;

  logic [7:0]   rcon_tbl [0:9] = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                   8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  logic [127:0] exp_rk [0:10];

  aes_key_mem_rev dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .init      (init),
    .last_key  (last_key),
    .round     (round),
    .round_key (round_key),
    .ready     (ready),
    .valid     (valid),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv, p, s;
    logic [7:0] e;
    inv = 8'h01;
    p   = b;
    e   = 8'd254;
    for (int k = 0; k < 8; k++) begin
      if (e[k]) inv = gmul(inv, p);
      p = gmul(p, p);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  always_comb new_sboxw = subw(sboxw);

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [127:0] key);
    init     = 1'b1;
    last_key = key;
    tick();
    init     = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic read_round(input int r, output logic [127:0] k);
    round = 4'(r);
    #1;
    k = round_key;
  endtask

  initial begin
    logic [127:0] k;
    int           cyc;

    reset_n  = 1'b0;
    init     = 1'b0;
    last_key = '0;
    round    = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state and full read range
    check_eq("rst_ready", 128'(ready), 128'd1);
    check_eq("rst_valid", 128'(valid), 128'd0);
    check_eq("rst_sboxw", 128'(sboxw), 128'd0);
    for (int r = 0; r < 16; r++) begin
      read_round(r, k);
      check_eq($sformatf("rst_rk%0d", r), k, 128'd0);
    end

    // FIPS-197 run with rcon trace and exact latency
    start(FIPS_LAST);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("rcon%0d", i), 128'(dut.r_rcon), 128'(rcon_tbl[i]));
      check_eq($sformatf("gen_valid%0d", i), 128'(valid), 128'd0);
      if (i == 0) begin
        check_eq("gen_ready", 128'(ready), 128'd0);
        check_eq("sboxw_first", 128'(sboxw), 128'h5c006e57);
      end
      tick();
    end
    check_eq("fips_valid", 128'(valid), 128'd1);
    check_eq("fips_ready", 128'(ready), 128'd1);
    check_eq("rcon_final", 128'(dut.r_rcon), 128'h8d);
    check_eq("idle_sboxw", 128'(sboxw), 128'd0);
    read_round(0, k);  check_eq("fips_rk0", k, FIPS_KEY);
    read_round(1, k);  check_eq("fips_rk1", k, FIPS_RK1);
    read_round(9, k);  check_eq("fips_rk9", k, FIPS_RK9);
    read_round(10, k); check_eq("fips_rk10", k, FIPS_LAST);
    expand_key(FIPS_KEY);
    for (int r = 0; r < 11; r++) begin
      read_round(r, k);
      check_eq($sformatf("fips_model_rk%0d", r), k, exp_rk[r]);
    end
    for (int r = 11; r < 16; r++) begin
      read_round(r, k);
      check_eq($sformatf("oor_rk%0d", r), k, 128'd0);
    end

    // init pulse mid-run is ignored
    start(FIPS_LAST);
    repeat (3) tick();
    init     = 1'b1;
    last_key = {128{1'b1}};
    tick();
    init = 1'b0;
    wait_valid(cyc);
    check_eq("ign_latency", 128'(cyc), 128'd6);
    read_round(0, k);  check_eq("ign_rk0", k, FIPS_KEY);
    read_round(10, k); check_eq("ign_rk10", k, FIPS_LAST);

    // Reset mid-run, then a fresh run
    start(FIPS_LAST);
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    check_eq("mrst_ready", 128'(ready), 128'd1);
    check_eq("mrst_valid", 128'(valid), 128'd0);
    check_eq("mrst_rcon", 128'(dut.r_rcon), 128'd0);
    read_round(0, k);  check_eq("mrst_rk0", k, 128'd0);
    read_round(5, k);  check_eq("mrst_rk5", k, 128'd0);
    read_round(10, k); check_eq("mrst_rk10", k, 128'd0);
    reset_n = 1'b1;
    tick();
    start(FIPS_LAST);
    wait_valid(cyc);
    check_eq("fresh_latency", 128'(cyc), 128'd10);
    read_round(0, k); check_eq("fresh_rk0", k, FIPS_KEY);
    read_round(9, k); check_eq("fresh_rk9", k, FIPS_RK9);

    // Back-to-back run with an all-zero last key
    start(128'd0);
    check_eq("b2b_valid_drop", 128'(valid), 128'd0);
    check_eq("b2b_ready_drop", 128'(ready), 128'd0);
    wait_valid(cyc);
    check_eq("b2b_latency", 128'(cyc), 128'd10);
    read_round(10, k); check_eq("b2b_rk10", k, 128'd0);
    read_round(0, k);
    expand_key(k);
    check_eq("b2b_fwd_rk10", exp_rk[10], 128'd0);
    for (int r = 1; r < 10; r++) begin
      read_round(r, k);
      check_eq($sformatf("b2b_model_rk%0d", r), k, exp_rk[r]);
    end
    read_round(12, k); check_eq("b2b_oor_rk12", k, 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_key_mem_rev.md
# aes_key_mem_rev

Reverse AES-128 key schedule generator for decrypt-only use. Given the final (round 10) round key, it walks the schedule backwards one round per cycle, using the inverse rcon sequence (0x36, 0x1b, 0x80 … 0x01). It stores all 11 round keys for random access by the decipher datapath and recovers the original cipher key as round 0. It sits beside the decipher core and borrows the core's shared word-wide S-box through a combinational request/response port.

## Interface
- AES128_ROUNDS, 10: number of rounds. Fixed; the schedule holds 11 keys.
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- init  in  1  start regeneration from last_key; single-cycle pulse
- last_key  in  128  round-10 key, word0 in [127:96]; sampled on the init edge
- round  in  4  read index, 0..10
- round_key  out  128  stored key for `round`; combinational; all zeros when round > 10
- ready  out  1  idle, able to accept init
- valid  out  1  full schedule present in memory
- sboxw  out  32  S-box request word
- new_sboxw  in  32  S-box result, bytewise SubBytes of sboxw, same cycle

## Operation
- Reset values: all 11 key entries 0, ready=1, valid=0, round counter 0, rcon 0x00, state IDLE, sboxw=0.
- State IDLE, on init=1 at an edge:
  - key[10] <= last_key; work <= last_key.
  - rcon <= 0x36; ctr <= 10.
  - ready <= 0; valid <= 0; go to GEN.
  - init while not in IDLE is ignored.
- State GEN, one step per edge. Let work = w0|w1|w2|w3.
  - Compute p3 = w3^w2, p2 = w2^w1, p1 = w1^w0.
  - sboxw = RotWord(p3) = {p3[23:0], p3[31:24]}.
  - p0 = w0 ^ new_sboxw ^ {rcon, 24'h0}.
  - At the edge: key[ctr-1] <= p0|p1|p2|p3; work <= same; ctr <= ctr-1.
  - rcon <= inv_xtime(rcon), where inv_xtime(r) = r[0] ? ((r^8'h1b)>>1)|8'h80 : r>>1.
  - If ctr==1 at the edge: ready <= 1, valid <= 1, go to IDLE.
- sboxw is 0 outside GEN. The core arbiter grants the S-box to this block while ready=0.
- Reads are always allowed. During GEN, entries not yet written return the previous schedule, or 0 after reset. Callers gate on valid.
- Reset mid-GEN aborts the run and restores all reset values.

## Timing
- init sampled at edge E: key[10] visible after E. key[9] after E+1, …, key[0] after E+10.
- ready=1 and valid=1 also take effect after E+10, so the total latency is 10 cycles after the init edge.
- init at E+10+1 is accepted and restarts the run. valid drops after that edge.
- Rcon per step, in order: 36, 1b, 80, 40, 20, 10, 08, 04, 02, 01. rcon after the run is 0x8d.
- round_key has combinational read latency 0.

## Structure
- Shared package aes_pkg holds:
  - AES128_ROUNDS.
  - RCON_LAST = 8'h36.
  - Function inv_xtime.
  - RotWord helper.
  - State encoding IDLE/GEN.
- Sub-module aes_key_rev_step (combinational): inputs work and rcon and new_sboxw; outputs sboxw and prev_key.
  - Used so the verifier can unit-test one inverse step.
- Top level holds the FSM, counter, rcon register and 11×128 register array.

## Test plan
- FIPS-197 A.1 key. Stimulus: init with last_key = d014f9a8c9ee2589e13f0cc8b6630ca6 (a behavioral bench S-box answers sboxw). Required response:
  - valid after 10 cycles.
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 9 = ac7766f319fadc2128d12941575c006e.
- Rcon trace: log rcon during GEN -> 36,1b,80,40,20,10,08,04,02,01; final 0x8d.
- Reset and read range: after reset, ready=1 and valid=0. Required responses:
  - every round reads 0;
  - round=11..15 reads 0 always, including after a valid run.
- init during GEN: pulse init at E+4 with a different key -> ignored; the result equals the first-key schedule.
- Reset mid-GEN: assert reset_n=0 at E+5 -> next cycle all keys 0, ready=1, valid=0. A fresh init then completes correctly.
- Back-to-back runs: init again on the cycle after valid, using an all-zero last key. Required response:
  - valid falls, then rises after 10 cycles;
  - round 10 = 0;
  - round 0 matches a software inverse schedule.
